// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit.
//   fwd_sel_t       : EX operand source select (00 regfile, 01 EX/MEM, 10 MEM/WB)
//   hazard_shadow_t : in-flight instruction summary tracked per stage
//   fwd_pick()      : newest-producer-wins forwarding decision for one source
package pipeline_hazard_unit_pkg;

  // Shadow rd storage is sized for the widest register id any core may use.
  // Narrower ids are zero-extended before they are stored or compared.
  localparam int SHADOW_ID_W = 8;

  localparam logic [SHADOW_ID_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_NONE   = 2'b00,
    FWD_EX_MEM = 2'b01,
    FWD_MEM_WB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                   valid;
    logic [SHADOW_ID_W-1:0] rd_id;
    logic                   reg_write;
    logic                   mem_read;
  } hazard_shadow_t;

  // A stage can supply a result only if it really writes a nonzero register.
  function automatic logic produces(hazard_shadow_t s, logic [SHADOW_ID_W-1:0] rs);
    return s.valid & s.reg_write & (s.rd_id != REG_ZERO) & (s.rd_id == rs);
  endfunction

  // EX is checked first: the younger producer holds the architecturally
  // current value when both EX and MEM write the same register.
  function automatic fwd_sel_t fwd_pick(hazard_shadow_t ex, hazard_shadow_t mem,
                                        logic [SHADOW_ID_W-1:0] rs, logic used);
    if (!used)                return FWD_NONE;
    else if (produces(ex, rs))  return FWD_EX_MEM;
    else if (produces(mem, rs)) return FWD_MEM_WB;
    else                      return FWD_NONE;
  endfunction

endpackage

// File: rtl/pipeline_hazard_unit_sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
//   clk, reset_n : clock, async active-low reset (clears count)
//   inc          : add one this cycle
//   count        : current value, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 count <= '0;
    else if (inc && (count != '1)) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Stall / flush / forwarding controller for the 5-stage pipeline.
// Inputs : ID instruction summary (valid, rs1/rs2 + used flags, rd, reg_write,
//          mem_read), ex_branch_taken, mem_busy.
// Outputs: per-register enables and flush/bubble controls, registered EX
//          forwarding selects, {WB,MEM,EX,ID} valid, saturating stall and
//          flush counters.
// Priority: mem_busy freeze > taken branch > load-use > normal advance.
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int REG_ID_W        = 6,
  parameter int CNT_W           = 32,
  parameter bit FLUSH_ON_BRANCH = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                id_valid,
  input  logic [REG_ID_W-1:0] id_rs1_id,
  input  logic [REG_ID_W-1:0] id_rs2_id,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic [REG_ID_W-1:0] id_rd_id,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                ex_branch_taken,
  input  logic                mem_busy,
  output logic                pc_en,
  output logic                if_id_en,
  output logic                if_id_flush,
  output logic                id_ex_en,
  output logic                id_ex_flush,
  output logic                ex_mem_en,
  output logic                mem_wb_bubble,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic [3:0]          stage_valid,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  hazard_shadow_t ex_sh, mem_sh, wb_sh;
  fwd_sel_t       fwd_a, fwd_b;

  logic [SHADOW_ID_W-1:0] rs1_x, rs2_x, rd_x;
  assign rs1_x = SHADOW_ID_W'(id_rs1_id);
  assign rs2_x = SHADOW_ID_W'(id_rs2_id);
  assign rd_x  = SHADOW_ID_W'(id_rd_id);

  logic freeze, branch, flush_br, lu_cond, load_use, ex_flush;

  assign freeze   = mem_busy;
  assign branch   = ~freeze & ex_branch_taken;
  assign flush_br = branch & FLUSH_ON_BRANCH;

  // Load in EX whose result the ID instruction needs: it cannot be
  // forwarded until the load reaches MEM, so hold ID for one cycle.
  assign lu_cond = id_valid & ex_sh.valid & ex_sh.mem_read & (ex_sh.rd_id != REG_ZERO) &
                   ((id_rs1_used & (rs1_x == ex_sh.rd_id)) |
                    (id_rs2_used & (rs2_x == ex_sh.rd_id)));
  // A taken branch outranks the stall whether or not it flushes.
  assign load_use = ~freeze & ~ex_branch_taken & lu_cond;
  assign ex_flush = flush_br | load_use;

  // Controls are forced low while reset is held.
  assign pc_en         = reset_n & ~freeze & ~load_use;
  assign if_id_en      = reset_n & ~freeze & ~load_use;
  assign if_id_flush   = reset_n & flush_br;
  assign id_ex_en      = reset_n & ~freeze;
  assign id_ex_flush   = reset_n & ex_flush;
  assign ex_mem_en     = reset_n & ~freeze;
  assign mem_wb_bubble = reset_n & freeze;

  // Shadows move exactly when ID/EX, EX/MEM and MEM/WB move; a freeze
  // holds the whole back end, so the shadows and selects hold as well.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_sh  <= '0;
      mem_sh <= '0;
      wb_sh  <= '0;
      fwd_a  <= FWD_NONE;
      fwd_b  <= FWD_NONE;
    end else if (!freeze) begin
      if (ex_flush) begin
        ex_sh <= '0;
        fwd_a <= FWD_NONE;
        fwd_b <= FWD_NONE;
      end else begin
        ex_sh <= '{valid: id_valid, rd_id: rd_x, reg_write: id_reg_write, mem_read: id_mem_read};
        // Current EX/MEM become MEM/WB once this instruction sits in EX.
        fwd_a <= fwd_pick(ex_sh, mem_sh, rs1_x, id_rs1_used);
        fwd_b <= fwd_pick(ex_sh, mem_sh, rs2_x, id_rs2_used);
      end
      mem_sh <= ex_sh;
      wb_sh  <= mem_sh;
    end
  end

  assign fwd_a_sel   = fwd_a;
  assign fwd_b_sel   = fwd_b;
  assign stage_valid = {wb_sh.valid, mem_sh.valid, ex_sh.valid, id_valid & reset_n};

  // WB only reports occupancy (the regfile is write-first) and MEM never
  // stalls on a load, so these shadow fields are tracked but not consumed.
  logic unused_fields;
  assign unused_fields = ^{mem_sh.mem_read, wb_sh.rd_id, wb_sh.reg_write, wb_sh.mem_read};

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset_n(reset_n), .inc(freeze | load_use), .count(stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset_n(reset_n), .inc(flush_br), .count(flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit. Three instances share stimulus:
// default parameters, FLUSH_ON_BRANCH=0, and CNT_W=4 for saturation.
// ctl vectors are {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
// ex_mem_en, mem_wb_bubble}.
module tb_pipeline_hazard_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
  logic [5:0] id_rs1_id, id_rs2_id, id_rd_id;
  logic ex_branch_taken, mem_busy;

  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [3:0] stage_valid;
  logic [31:0] stall_cnt, flush_cnt;

  logic nf_pc_en, nf_if_id_en, nf_if_id_flush, nf_id_ex_en, nf_id_ex_flush, nf_ex_mem_en, nf_mem_wb_bubble;
  logic [1:0] nf_fwd_a_sel, nf_fwd_b_sel;
  logic [3:0] nf_stage_valid;
  logic [31:0] nf_stall_cnt, nf_flush_cnt;

  logic c4_pc_en, c4_if_id_en, c4_if_id_flush, c4_id_ex_en, c4_id_ex_flush, c4_ex_mem_en, c4_mem_wb_bubble;
  logic [1:0] c4_fwd_a_sel, c4_fwd_b_sel;
  logic [3:0] c4_stage_valid;
  logic [3:0] c4_stall_cnt, c4_flush_cnt;

  logic [6:0] ctl, nf_ctl;
  assign ctl    = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble};
  assign nf_ctl = {nf_pc_en, nf_if_id_en, nf_if_id_flush, nf_id_ex_en, nf_id_ex_flush, nf_ex_mem_en, nf_mem_wb_bubble};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_id(id_rd_id), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_bubble(mem_wb_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stage_valid(stage_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_unit #(.FLUSH_ON_BRANCH(1'b0)) dut_nf (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_id(id_rd_id), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(nf_pc_en), .if_id_en(nf_if_id_en), .if_id_flush(nf_if_id_flush), .id_ex_en(nf_id_ex_en),
    .id_ex_flush(nf_id_ex_flush), .ex_mem_en(nf_ex_mem_en), .mem_wb_bubble(nf_mem_wb_bubble),
    .fwd_a_sel(nf_fwd_a_sel), .fwd_b_sel(nf_fwd_b_sel), .stage_valid(nf_stage_valid),
    .stall_cnt(nf_stall_cnt), .flush_cnt(nf_flush_cnt)
  );

  pipeline_hazard_unit #(.CNT_W(4)) dut_c4 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_id(id_rd_id), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(c4_pc_en), .if_id_en(c4_if_id_en), .if_id_flush(c4_if_id_flush), .id_ex_en(c4_id_ex_en),
    .id_ex_flush(c4_id_ex_flush), .ex_mem_en(c4_ex_mem_en), .mem_wb_bubble(c4_mem_wb_bubble),
    .fwd_a_sel(c4_fwd_a_sel), .fwd_b_sel(c4_fwd_b_sel), .stage_valid(c4_stage_valid),
    .stall_cnt(c4_stall_cnt), .flush_cnt(c4_flush_cnt)
  );

  task automatic set_id(input logic v, input logic [5:0] rs1, input logic u1, input logic [5:0] rs2,
                        input logic u2, input logic [5:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rs1_id = rs1; id_rs1_used = u1; id_rs2_id = rs2; id_rs2_used = u2;
    id_rd_id = rd; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic nop;
    set_id(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    ex_branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk); nop; reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_reset;
    set_id(1'b1, 6'd5, 1'b1, 6'd6, 1'b1, 6'd7, 1'b1, 1'b1);
    ex_branch_taken = 1'b1; mem_busy = 1'b1;
    #2;
    checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL reset_ctl got %b want 0000000", ctl); end
    checks++; if (stage_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", stage_valid); end
    checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin errors++; $display("FAIL reset_fwd got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    @(negedge clk); nop; reset_n = 1'b1;
  endtask

  task automatic test_load_use;
    do_reset;
    set_id(1'b1, 6'd1, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1);   // lw x5
    @(negedge clk);
    set_id(1'b1, 6'd5, 1'b1, 6'd6, 1'b1, 6'd7, 1'b1, 1'b0);   // add x7,x5,x6
    #1;
    checks++; if (ctl !== 7'b0001110) begin errors++; $display("FAIL lu_ctl got %b want 0001110", ctl); end
    checks++; if (stage_valid !== 4'b0011) begin errors++; $display("FAIL lu_valid got %b want 0011", stage_valid); end
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_stall got %0d want 1", stall_cnt); end
    checks++; if (stage_valid !== 4'b0101) begin errors++; $display("FAIL lu_bubble_valid got %b want 0101", stage_valid); end
    #1;
    checks++; if (ctl !== 7'b1101010) begin errors++; $display("FAIL lu_release got %b want 1101010", ctl); end
    @(negedge clk);
    checks++; if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin errors++; $display("FAIL lu_fwd got %b/%b want 10/00", fwd_a_sel, fwd_b_sel); end
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_stall_once got %0d want 1", stall_cnt); end
    checks++; if (stage_valid !== 4'b1011) begin errors++; $display("FAIL lu_after_valid got %b want 1011", stage_valid); end
    nop;
  endtask

  task automatic test_back_to_back;
    do_reset;
    set_id(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 1'b1, 1'b0);   // add x3,x1,x2
    @(negedge clk);
    set_id(1'b1, 6'd3, 1'b1, 6'd3, 1'b1, 6'd4, 1'b1, 1'b0);   // sub x4,x3,x3
    #1;
    checks++; if (ctl !== 7'b1101010) begin errors++; $display("FAIL b2b_nostall got %b want 1101010", ctl); end
    @(negedge clk);
    checks++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin errors++; $display("FAIL b2b_fwd got %b/%b want 01/01", fwd_a_sel, fwd_b_sel); end
    set_id(1'b1, 6'd3, 1'b1, 6'd4, 1'b1, 6'd8, 1'b1, 1'b0);   // x3 one apart, x4 adjacent
    @(negedge clk);
    checks++; if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b01) begin errors++; $display("FAIL apart_fwd got %b/%b want 10/01", fwd_a_sel, fwd_b_sel); end
    set_id(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd3, 1'b1, 1'b0);   // x3 writer (older)
    @(negedge clk);
    set_id(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd3, 1'b1, 1'b0);   // x3 writer (newer)
    @(negedge clk);
    set_id(1'b1, 6'd3, 1'b1, 6'd0, 1'b1, 6'd9, 1'b1, 1'b0);   // reads x3 and x0
    @(negedge clk);
    checks++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin errors++; $display("FAIL newest_fwd got %b/%b want 01/00", fwd_a_sel, fwd_b_sel); end
    nop;
  endtask

  task automatic test_branch;
    do_reset;
    set_id(1'b1, 6'd1, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1);   // lw x5
    @(negedge clk);
    set_id(1'b1, 6'd5, 1'b1, 6'd0, 1'b0, 6'd7, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== 7'b1111110) begin errors++; $display("FAIL br_ctl got %b want 1111110", ctl); end
    checks++; if (nf_ctl !== 7'b1101010) begin errors++; $display("FAIL br_noflush_ctl got %b want 1101010", nf_ctl); end
    @(negedge clk);
    ex_branch_taken = 1'b0;
    checks++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin errors++; $display("FAIL br_cnt got %0d/%0d want 1/0", flush_cnt, stall_cnt); end
    checks++; if (nf_flush_cnt !== 32'd0) begin errors++; $display("FAIL br_noflush_cnt got %0d want 0", nf_flush_cnt); end
    checks++; if (stage_valid[1] !== 1'b0 || nf_stage_valid[1] !== 1'b1) begin errors++; $display("FAIL br_ex_valid got %b/%b want 0/1", stage_valid[1], nf_stage_valid[1]); end
    nop;
  endtask

  task automatic test_freeze;
    do_reset;
    set_id(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd3, 1'b1, 1'b0);   // writes x3
    @(negedge clk);
    set_id(1'b1, 6'd3, 1'b1, 6'd0, 1'b0, 6'd9, 1'b1, 1'b0);   // reads x3
    @(negedge clk);
    checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL frz_setup_fwd got %b want 01", fwd_a_sel); end
    set_id(1'b1, 6'd9, 1'b1, 6'd0, 1'b0, 6'd10, 1'b1, 1'b0);
    mem_busy = 1'b1; ex_branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== 7'b0000001) begin errors++; $display("FAIL frz_ctl got %b want 0000001", ctl); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL frz_fwd_hold[%0d] got %b want 01", i, fwd_a_sel); end
    end
    checks++; if (stall_cnt !== 32'd3 || flush_cnt !== 32'd0) begin errors++; $display("FAIL frz_cnt got %0d/%0d want 3/0", stall_cnt, flush_cnt); end
    mem_busy = 1'b0;
    #1;
    checks++; if (ctl !== 7'b1111110) begin errors++; $display("FAIL frz_branch_ctl got %b want 1111110", ctl); end
    @(negedge clk);
    checks++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd3) begin errors++; $display("FAIL frz_after_cnt got %0d/%0d want 1/3", flush_cnt, stall_cnt); end
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL frz_flush_fwd got %b want 00", fwd_a_sel); end
    nop;
  endtask

  task automatic test_x0;
    do_reset;
    set_id(1'b1, 6'd1, 1'b1, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1);   // lw x0
    @(negedge clk);
    set_id(1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 6'd4, 1'b1, 1'b0);   // uses x0
    #1;
    checks++; if (ctl !== 7'b1101010) begin errors++; $display("FAIL x0_nostall got %b want 1101010", ctl); end
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin errors++; $display("FAIL x0_fwd got %0d %b/%b want 0 00/00", stall_cnt, fwd_a_sel, fwd_b_sel); end
    set_id(1'b1, 6'd0, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1, 1'b0);   // x0 with load in MEM
    @(negedge clk);
    checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL x0_mem_fwd got %b want 00", fwd_a_sel); end
    nop;
  endtask

  task automatic test_async_reset;
    do_reset;
    set_id(1'b1, 6'd1, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1);   // lw x5
    @(negedge clk);
    set_id(1'b1, 6'd5, 1'b1, 6'd0, 1'b0, 6'd7, 1'b1, 1'b0);
    mem_busy = 1'b1;
    @(negedge clk);
    mem_busy = 1'b0;
    #1;
    checks++; if (ctl !== 7'b0001110 || stall_cnt !== 32'd1) begin errors++; $display("FAIL ar_pre got %b %0d want 0001110 1", ctl, stall_cnt); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL ar_ctl got %b want 0000000", ctl); end
    checks++; if (stall_cnt !== 32'd0 || stage_valid !== 4'b0000) begin errors++; $display("FAIL ar_state got %0d %b want 0 0000", stall_cnt, stage_valid); end
    @(negedge clk); nop; reset_n = 1'b1;
  endtask

  task automatic test_saturate;
    do_reset;
    mem_busy = 1'b1;
    repeat (14) @(negedge clk);
    checks++; if (c4_stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_pre got %0d want 14", c4_stall_cnt); end
    repeat (5) @(negedge clk);
    checks++; if (c4_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", c4_stall_cnt); end
    checks++; if (stall_cnt !== 32'd19) begin errors++; $display("FAIL sat_wide got %0d want 19", stall_cnt); end
    nop;
  endtask

  initial begin
    nop;
    test_reset;
    test_load_use;
    test_back_to_back;
    test_branch;
    test_freeze;
    test_x0;
    test_async_reset;
    test_saturate;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
